washing_machine_fsm: RTL and testbench

- Moore-style controller for a front-load washing machine.
- Sequences fill, wash, drain, spin and end phases from panel buttons, door and water-level sensors, and an external timer done flag.
- Drives actuator enables, the external timer's duration select, and one-hot status flags for the front-panel display.
- Sits between the user-panel/sensor inputs and the actuator/timer block.

---
 rtl/washing_machine_fsm.sv | 156 +++++++++++++++
 tb/tb_washing_machine_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/washing_machine_fsm.sv
// Moore controller for a front-load washing machine: sequences fill, wash, drain,
// spin and end phases, and drives the actuators, timer select and panel flags.
module washing_machine_fsm #(
   parameter logic [2:0] IDLE_ST      = 3'b111,
   parameter logic [2:0] FILL_MED_ST  = 3'b110,
   parameter logic [2:0] FILL_HIGH_ST = 3'b101,
   parameter logic [2:0] ACTIVATE_ST  = 3'b100,
   parameter logic [2:0] DRAIN_ST     = 3'b000,
   parameter logic [2:0] SPIN_ST      = 3'b001,
   parameter logic [2:0] END_ST       = 3'b011
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ON_SUMMER,
   input  logic       ON_WINTER,
   input  logic       TIMER_DONE,
   input  logic       DOOR_SENSOR,
   input  logic       WATER_SENSOR_M,
   input  logic       WATER_SENSOR_H,
   output logic [1:0] TIMER_SEL,
   output logic       TIMER_EN,
   output logic       WASHER_EN,
   output logic       WATER_EN,
   output logic       SPIN_EN,
   output logic       DRAIN_EN,
   output logic       FILLING,
   output logic       ACTIVE,
   output logic       DRAIN,
   output logic       SPIN,
   output logic       IDLE,
   output logic       DONE
);

   typedef enum logic [2:0] {
      S_IDLE      = IDLE_ST,
      S_FILL_MED  = FILL_MED_ST,
      S_FILL_HIGH = FILL_HIGH_ST,
      S_ACTIVATE  = ACTIVATE_ST,
      S_DRAIN     = DRAIN_ST,
      S_SPIN      = SPIN_ST,
      S_END       = END_ST
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_MED  = 2'b01;
   localparam logic [1:0] SEL_HIGH = 2'b10;
   localparam logic [1:0] SEL_SPIN = 2'b11;

   state_t state;
   state_t next_state;
   logic   mode;
   logic   next_mode;

   // mode remembers the chosen program so the wash phase picks the right duration
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
         mode  <= 1'b0;
      end else begin
         state <= next_state;
         mode  <= next_mode;
      end
   end

   always_comb begin
      next_state = state;
      next_mode  = mode;
      case (state)
         S_IDLE: begin
            if (DOOR_SENSOR && ON_SUMMER) begin
               next_state = S_FILL_MED;
               next_mode  = 1'b0;
            end else if (DOOR_SENSOR && ON_WINTER) begin
               next_state = S_FILL_HIGH;
               next_mode  = 1'b1;
            end
         end
         S_FILL_MED: begin
            if (WATER_SENSOR_M) next_state = S_ACTIVATE;
         end
         S_FILL_HIGH: begin
            if (WATER_SENSOR_H) next_state = S_ACTIVATE;
         end
         S_ACTIVATE: begin
            if (TIMER_DONE) next_state = S_DRAIN;
         end
         // keep pumping until both level sensors report the drum is empty
         S_DRAIN: begin
            if (!WATER_SENSOR_M && !WATER_SENSOR_H) next_state = S_SPIN;
         end
         S_SPIN: begin
            if (TIMER_DONE) next_state = S_END;
         end
         S_END: begin
            if (!DOOR_SENSOR) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      TIMER_SEL = SEL_NONE;
      TIMER_EN  = 1'b0;
      WASHER_EN = 1'b0;
      WATER_EN  = 1'b0;
      SPIN_EN   = 1'b0;
      DRAIN_EN  = 1'b0;
      FILLING   = 1'b0;
      ACTIVE    = 1'b0;
      DRAIN     = 1'b0;
      SPIN      = 1'b0;
      IDLE      = 1'b0;
      DONE      = 1'b0;
      case (state)
         S_IDLE: begin
            IDLE = 1'b1;
         end
         S_FILL_MED, S_FILL_HIGH: begin
            FILLING  = 1'b1;
            WATER_EN = 1'b1;
         end
         S_ACTIVATE: begin
            ACTIVE    = 1'b1;
            WASHER_EN = 1'b1;
            TIMER_EN  = 1'b1;
            TIMER_SEL = mode ? SEL_HIGH : SEL_MED;
         end
         S_DRAIN: begin
            DRAIN    = 1'b1;
            DRAIN_EN = 1'b1;
         end
         S_SPIN: begin
            SPIN      = 1'b1;
            SPIN_EN   = 1'b1;
            TIMER_EN  = 1'b1;
            TIMER_SEL = SEL_SPIN;
         end
         S_END: begin
            DONE = 1'b1;
         end
         // unused encodings present as idle so the panel never goes blank
         default: begin
            IDLE = 1'b1;
         end
      endcase
   end

`ifndef SYNTHESIS
   status_onehot: assert property (@(posedge CLK)
      $onehot({FILLING, ACTIVE, DRAIN, SPIN, IDLE, DONE}));

   motors_exclusive: assert property (@(posedge CLK)
      $onehot0({WASHER_EN, SPIN_EN, WATER_EN, DRAIN_EN}));
`endif

endmodule

// File: tb/tb_washing_machine_fsm.sv
// Directed self-checking bench for washing_machine_fsm: summer and winter cycles,
// door/button interlocks and asynchronous mid-cycle reset.
module tb_washing_machine_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ON_SUMMER, ON_WINTER, TIMER_DONE, DOOR_SENSOR;
   logic       WATER_SENSOR_M, WATER_SENSOR_H;
   logic [1:0] TIMER_SEL;
   logic       TIMER_EN, WASHER_EN, WATER_EN, SPIN_EN, DRAIN_EN;
   logic       FILLING, ACTIVE, DRAIN, SPIN, IDLE, DONE;

   int compared   = 0;
   int mismatched = 0;

   // {sel[1:0], timer_en, washer_en, water_en, spin_en, drain_en,
   //  filling, active, drain, spin, idle, done}
   localparam logic [12:0] EXP_IDLE     = 13'b00_00000_000010;
   localparam logic [12:0] EXP_FILL     = 13'b00_00100_100000;
   localparam logic [12:0] EXP_ACT_MED  = 13'b01_11000_010000;
   localparam logic [12:0] EXP_ACT_HIGH = 13'b10_11000_010000;
   localparam logic [12:0] EXP_DRAIN    = 13'b00_00001_001000;
   localparam logic [12:0] EXP_SPIN     = 13'b11_10010_000100;
   localparam logic [12:0] EXP_DONE     = 13'b00_00000_000001;

   washing_machine_fsm dut (
      .CLK            (CLK),
      .RST            (RST),
      .ON_SUMMER      (ON_SUMMER),
      .ON_WINTER      (ON_WINTER),
      .TIMER_DONE     (TIMER_DONE),
      .DOOR_SENSOR    (DOOR_SENSOR),
      .WATER_SENSOR_M (WATER_SENSOR_M),
      .WATER_SENSOR_H (WATER_SENSOR_H),
      .TIMER_SEL      (TIMER_SEL),
      .TIMER_EN       (TIMER_EN),
      .WASHER_EN      (WASHER_EN),
      .WATER_EN       (WATER_EN),
      .SPIN_EN        (SPIN_EN),
      .DRAIN_EN       (DRAIN_EN),
      .FILLING        (FILLING),
      .ACTIVE         (ACTIVE),
      .DRAIN          (DRAIN),
      .SPIN           (SPIN),
      .IDLE           (IDLE),
      .DONE           (DONE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [12:0] observed();
      return {TIMER_SEL, TIMER_EN, WASHER_EN, WATER_EN, SPIN_EN, DRAIN_EN,
              FILLING, ACTIVE, DRAIN, SPIN, IDLE, DONE};
   endfunction

   task automatic check_output(input string tag, input logic [12:0] actual,
                               input logic [12:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
      end
   endtask

   // drive inputs away from the edge, then let one rising edge happen
   task automatic apply_stimulus(input logic summer, input logic winter,
                                 input logic tdone, input logic door,
                                 input logic wm, input logic wh);
      ON_SUMMER      = summer;
      ON_WINTER      = winter;
      TIMER_DONE     = tdone;
      DOOR_SENSOR    = door;
      WATER_SENSOR_M = wm;
      WATER_SENSOR_H = wh;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST            = 1'b0;
      ON_SUMMER      = 1'b1;
      ON_WINTER      = 1'b0;
      TIMER_DONE     = 1'b0;
      DOOR_SENSOR    = 1'b1;
      WATER_SENSOR_M = 1'b0;
      WATER_SENSOR_H = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check_output("reset_held", observed(), EXP_IDLE);
      RST = 1'b1;
      #1;
      check_output("reset_release", observed(), EXP_IDLE);

      // summer cycle (start button still held from reset)
      apply_stimulus(1, 0, 0, 1, 0, 0); check_output("sum_fill",       observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 0, 0); check_output("sum_fill_wait",  observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("sum_wash",       observed(), EXP_ACT_MED);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("sum_wash_wait",  observed(), EXP_ACT_MED);
      apply_stimulus(0, 0, 1, 1, 1, 0); check_output("sum_drain",      observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("sum_drain_wait", observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 0, 0); check_output("sum_spin",       observed(), EXP_SPIN);
      apply_stimulus(0, 0, 1, 1, 0, 0); check_output("sum_done",       observed(), EXP_DONE);
      apply_stimulus(0, 0, 0, 1, 0, 0); check_output("end_door_shut",  observed(), EXP_DONE);
      apply_stimulus(0, 0, 0, 0, 0, 0); check_output("sum_idle",       observed(), EXP_IDLE);

      // winter cycle
      apply_stimulus(0, 1, 0, 1, 0, 0); check_output("win_fill",       observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("win_fill_m",     observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 1, 1); check_output("win_wash",       observed(), EXP_ACT_HIGH);
      apply_stimulus(1, 1, 0, 1, 1, 1); check_output("win_btn_ignore", observed(), EXP_ACT_HIGH);
      apply_stimulus(0, 0, 1, 1, 1, 1); check_output("win_drain",      observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 1, 1); check_output("win_drain_mh",   observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("win_drain_m",    observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 0, 1); check_output("win_drain_h",    observed(), EXP_DRAIN);
      apply_stimulus(0, 0, 0, 1, 0, 0); check_output("win_spin",       observed(), EXP_SPIN);
      apply_stimulus(0, 0, 0, 1, 0, 0); check_output("win_spin_wait",  observed(), EXP_SPIN);
      apply_stimulus(0, 0, 1, 1, 0, 0); check_output("win_done",       observed(), EXP_DONE);
      apply_stimulus(0, 0, 0, 0, 0, 0); check_output("win_idle",       observed(), EXP_IDLE);

      // interlocks
      apply_stimulus(1, 0, 0, 0, 0, 0); check_output("door_open_sum",  observed(), EXP_IDLE);
      apply_stimulus(0, 1, 0, 0, 0, 0); check_output("door_open_win",  observed(), EXP_IDLE);
      apply_stimulus(1, 1, 0, 1, 0, 0); check_output("both_btn_fill",  observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 1, 0); check_output("both_btn_med",   observed(), EXP_ACT_MED);

      // asynchronous reset in the middle of the wash phase
      #3;
      RST = 1'b0;
      #1;
      check_output("async_reset", observed(), EXP_IDLE);
      apply_stimulus(1, 0, 0, 1, 1, 0); check_output("reset_hold",     observed(), EXP_IDLE);
      RST = 1'b1;
      apply_stimulus(0, 1, 0, 1, 0, 0); check_output("post_rst_fill",  observed(), EXP_FILL);
      apply_stimulus(0, 0, 0, 1, 1, 1); check_output("post_rst_wash",  observed(), EXP_ACT_HIGH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
